fp_add_scheduler: RTL

//  Shares one combinational FloatingPointAdder between NUM_REQ requesters.

---
 rtl/fp_add_scheduler.sv | 112 +++++++++++
 1 files changed

// File: rtl/fp_add_scheduler.sv
// Round-robin scheduler that shares one combinational FP adder among NUM_REQ requesters.
// Define FPSCHED_FASTPATH_EN to let a new grant overlap the response handshake (1 op / 2 cycles).
module fp_add_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [DATA_W*NUM_REQ-1:0] req_a,
  input  logic [DATA_W*NUM_REQ-1:0] req_b,
  output logic [DATA_W-1:0]         add_a,
  output logic [DATA_W-1:0]         add_b,
  input  logic [DATA_W-1:0]         add_out,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] ptr_nxt;
  logic [ID_W:0]   pick;
  logic            gnt_any;
  logic [ID_W-1:0] gnt_id;
  logic            arb_en;
  logic            grant;

  // Returns {found, index}; the nearest valid index at or after start wins.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                            input logic [ID_W-1:0]    start);
    logic [ID_W:0] res;
    int            idx;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(start) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (vld[idx[ID_W-1:0]]) res = {1'b1, idx[ID_W-1:0]};
    end
    return res;
  endfunction

  assign pick    = rr_pick(req_valid, ptr);
  assign gnt_any = pick[ID_W];
  assign gnt_id  = pick[ID_W-1:0];

`ifdef FPSCHED_FASTPATH_EN
  assign arb_en = (state == IDLE) || ((state == RESP) && rsp_ready);
`else
  assign arb_en = (state == IDLE);
`endif

  // Gating with rst_n keeps req_ready low for the whole reset assertion.
  assign grant   = arb_en && gnt_any && rst_n;
  assign ptr_nxt = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[gnt_id] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = grant ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand stage: granted operands drive the adder until the next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= '0;
      add_a  <= '0;
      add_b  <= '0;
      rsp_id <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        ptr    <= ptr_nxt;
        add_a  <= req_a[gnt_id*DATA_W +: DATA_W];
        add_b  <= req_b[gnt_id*DATA_W +: DATA_W];
        rsp_id <= gnt_id;
      end
    end
  end

  // Result stage: the adder has had a full cycle on stable operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= '0;
    end else if (state == ISSUE) begin
      rsp_data <= add_out;
    end
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

endmodule
